preg_freelist: RTL and testbench

- Circular free list of physical register indices for the rename/issue path.
- Supplies up to two free pregs per cycle to issue (preg1/preg2 of the issue/commit stage).
- Accepts up to two pregs per cycle released by commit, i.e. the old mappings overwritten in the committed RAT.
- Checkpoints its head pointer per branch tag; restores it on freelist_branch_shootdown so speculatively allocated pregs return to the list.

---
 rtl/preg_freelist_pkg.sv | 35 +++
 rtl/preg_freelist_if.sv | 44 ++++
 rtl/preg_freelist_chk.sv | 21 ++
 rtl/preg_freelist.sv | 131 +++++++++++++
 tb/tb_preg_freelist.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/preg_freelist_pkg.sv
// Shared sizes, index/pointer types and pointer helpers for the physical-register free list.
package preg_freelist_pkg;
  localparam int NUM_PREGS              = 64;
  localparam int MAX_PREDICT_DEPTH      = 4;
  localparam int MAX_PREDICT_DEPTH_BITS = 3;

  localparam int PREG_W     = $clog2(NUM_PREGS);
  localparam int PTR_W      = PREG_W + 1;
  localparam int CKPT_IDX_W = (MAX_PREDICT_DEPTH > 1) ? $clog2(MAX_PREDICT_DEPTH) : 1;

  typedef logic [PREG_W-1:0]                 preg_t;
  typedef logic [PTR_W-1:0]                  fl_count_t;
  typedef logic [MAX_PREDICT_DEPTH_BITS-1:0] br_tag_t;
  typedef logic [CKPT_IDX_W-1:0]             ckpt_idx_t;

  typedef struct packed {
    logic  wrap;
    preg_t idx;
  } freelist_ptr_t;

  function automatic freelist_ptr_t ptr_add(freelist_ptr_t p, logic [1:0] n);
    fl_count_t sum;
    sum = fl_count_t'(p) + fl_count_t'(n);
    return freelist_ptr_t'(sum);
  endfunction

  // Tag 0 is non-speculative and tags past the slot count have no checkpoint.
  function automatic logic tag_live(br_tag_t t);
    return (t != '0) && (int'(t) <= MAX_PREDICT_DEPTH);
  endfunction

  function automatic ckpt_idx_t tag_slot(br_tag_t t);
    return ckpt_idx_t'(t - br_tag_t'(1'b1));
  endfunction
endpackage

// File: rtl/preg_freelist_if.sv
// Allocate / release / checkpoint bundle between rename-commit logic and the free list.
// FREELIST_DOUBLE_FREE_CHECK_EN adds the double_free_err indication.
interface preg_freelist_if;
  import preg_freelist_pkg::*;

  logic [1:0] alloc_num;
  logic       alloc_en;
  logic       stalled;
  preg_t      preg1;
  preg_t      preg2;
  logic [1:0] free_num;
  preg_t      free_preg1;
  preg_t      free_preg2;
  logic       ckpt_en;
  br_tag_t    ckpt_tag;
  logic       freelist_branch_shootdown;
  br_tag_t    freelist_shootdown_branch_tag;
  fl_count_t  free_count;
`ifdef FREELIST_DOUBLE_FREE_CHECK_EN
  logic       double_free_err;

  modport master (
    output alloc_num, alloc_en, free_num, free_preg1, free_preg2,
           ckpt_en, ckpt_tag, freelist_branch_shootdown, freelist_shootdown_branch_tag,
    input  stalled, preg1, preg2, free_count, double_free_err
  );
  modport slave (
    input  alloc_num, alloc_en, free_num, free_preg1, free_preg2,
           ckpt_en, ckpt_tag, freelist_branch_shootdown, freelist_shootdown_branch_tag,
    output stalled, preg1, preg2, free_count, double_free_err
  );
`else
  modport master (
    output alloc_num, alloc_en, free_num, free_preg1, free_preg2,
           ckpt_en, ckpt_tag, freelist_branch_shootdown, freelist_shootdown_branch_tag,
    input  stalled, preg1, preg2, free_count
  );
  modport slave (
    input  alloc_num, alloc_en, free_num, free_preg1, free_preg2,
           ckpt_en, ckpt_tag, freelist_branch_shootdown, freelist_shootdown_branch_tag,
    output stalled, preg1, preg2, free_count
  );
`endif
endinterface

// File: rtl/preg_freelist_chk.sv
// Protocol checker: a release must never grow the list beyond NUM_PREGS entries.
module preg_freelist_chk
  import preg_freelist_pkg::*;
(
  input logic       clk,
  input logic       reset,
  input fl_count_t  free_count_i,
  input logic [1:0] alloc_amt_i,
  input logic [1:0] free_amt_i
);
  typedef logic [PTR_W:0] wide_t;

  wide_t next_count_s;

  assign next_count_s = wide_t'(free_count_i) - wide_t'(alloc_amt_i) + wide_t'(free_amt_i);

  // Overflowing releases are flagged; the datapath still performs the write.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
                                  next_count_s <= wide_t'(NUM_PREGS))
    else $error("preg_freelist: release overflows the free list");
endmodule

// File: rtl/preg_freelist.sv
// Circular free list of physical registers with per-branch head checkpoints.
// Optional FREELIST_DOUBLE_FREE_CHECK_EN drops releases of pregs already on the list.
module preg_freelist
  import preg_freelist_pkg::*;
(
  input logic            clk,
  input logic            reset,
  preg_freelist_if.slave fl
);
  preg_t         mem_q [NUM_PREGS];
  freelist_ptr_t ckpt_q [MAX_PREDICT_DEPTH];
  freelist_ptr_t head_q, head_d, tail_q, tail_d;
  freelist_ptr_t head_post_s;
  fl_count_t     count_s;
  preg_t         peek2_idx_s, wr_a_idx_s, wr_b_idx_s, wr_a_data_s;
  logic          stalled_s, shoot_s, alloc_s, ckpt_we_s;
  logic          req1_s, req2_s, acc1_s, acc2_s, wr_a_en_s, wr_b_en_s;
  logic [1:0]    alloc_amt_s, free_amt_s;

  assign count_s     = fl_count_t'(tail_q) - fl_count_t'(head_q);
  assign stalled_s   = count_s < fl_count_t'(fl.alloc_num);
  assign peek2_idx_s = head_q.idx + preg_t'(1'b1);

  assign fl.stalled    = stalled_s;
  assign fl.free_count = count_s;
  assign fl.preg1      = mem_q[head_q.idx];
  assign fl.preg2      = mem_q[peek2_idx_s];

  // Head movement: shootdown restores a checkpoint and overrides any allocation.
  always_comb begin
    shoot_s     = fl.freelist_branch_shootdown && tag_live(fl.freelist_shootdown_branch_tag);
    alloc_s     = fl.alloc_en && !stalled_s && !shoot_s;
    alloc_amt_s = alloc_s ? fl.alloc_num : 2'd0;
    head_post_s = ptr_add(head_q, alloc_amt_s);
    if (shoot_s) begin
      head_d = ckpt_q[tag_slot(fl.freelist_shootdown_branch_tag)];
    end else begin
      head_d = head_post_s;
    end
    ckpt_we_s = fl.ckpt_en && tag_live(fl.ckpt_tag) &&
                !(shoot_s && (fl.ckpt_tag >= fl.freelist_shootdown_branch_tag));
  end

`ifdef FREELIST_DOUBLE_FREE_CHECK_EN
  logic [NUM_PREGS-1:0] is_free_q, is_free_d;
  logic                 dfe_q, dfe_d;

  assign fl.double_free_err = dfe_q;
`endif

  // Release path: accepted releases are packed onto tail, tail+1 in order.
  always_comb begin
    req1_s = fl.free_num != 2'd0;
    req2_s = fl.free_num[1];
`ifdef FREELIST_DOUBLE_FREE_CHECK_EN
    acc1_s = req1_s && !is_free_q[fl.free_preg1];
    acc2_s = req2_s && !is_free_q[fl.free_preg2] &&
             !(acc1_s && (fl.free_preg1 == fl.free_preg2));
`else
    acc1_s = req1_s;
    acc2_s = req2_s;
`endif
    wr_a_en_s   = acc1_s || acc2_s;
    wr_b_en_s   = acc1_s && acc2_s;
    wr_a_data_s = acc1_s ? fl.free_preg1 : fl.free_preg2;
    wr_a_idx_s  = tail_q.idx;
    wr_b_idx_s  = tail_q.idx + preg_t'(1'b1);
    free_amt_s  = {1'b0, acc1_s} + {1'b0, acc2_s};
    tail_d      = ptr_add(tail_q, free_amt_s);
  end

`ifdef FREELIST_DOUBLE_FREE_CHECK_EN
  // Free-bit tracking: allocation clears, accepted release sets; shootdown leaves it alone.
  always_comb begin
    is_free_d = is_free_q;
    for (int i = 0; i < NUM_PREGS; i++) begin
      is_free_d[i] = (is_free_q[i] &&
                      !((alloc_amt_s != 2'd0) && (fl.preg1 == preg_t'(i))) &&
                      !((alloc_amt_s == 2'd2) && (fl.preg2 == preg_t'(i)))) ||
                     (acc1_s && (fl.free_preg1 == preg_t'(i))) ||
                     (acc2_s && (fl.free_preg2 == preg_t'(i)));
    end
    dfe_d = (req1_s && !acc1_s) || (req2_s && !acc2_s);
  end

  // Registered free bits and error pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      is_free_q <= {{(NUM_PREGS-1){1'b1}}, 1'b0};
      dfe_q     <= 1'b0;
    end else begin
      is_free_q <= is_free_d;
      dfe_q     <= dfe_d;
    end
  end
`endif

  // Pointers, checkpoints and list storage; preg 0 starts outside the list.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= freelist_ptr_t'(fl_count_t'(NUM_PREGS - 1));
      for (int i = 0; i < NUM_PREGS; i++) begin
        mem_q[i] <= preg_t'((i + 1) % NUM_PREGS);
      end
      for (int j = 0; j < MAX_PREDICT_DEPTH; j++) begin
        ckpt_q[j] <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      if (wr_a_en_s) begin
        mem_q[wr_a_idx_s] <= wr_a_data_s;
      end
      if (wr_b_en_s) begin
        mem_q[wr_b_idx_s] <= fl.free_preg2;
      end
      if (ckpt_we_s) begin
        ckpt_q[tag_slot(fl.ckpt_tag)] <= head_post_s;
      end
    end
  end

  preg_freelist_chk u_chk (
    .clk          (clk),
    .reset        (reset),
    .free_count_i (count_s),
    .alloc_amt_i  (alloc_amt_s),
    .free_amt_i   (free_amt_s)
  );
endmodule

// File: tb/tb_preg_freelist.sv
// Self-checking bench for preg_freelist: directed vectors plus randomized traffic vs a queue model.
module tb_preg_freelist;
  import preg_freelist_pkg::*;

  typedef struct {
    int an; int ae; int fn; int fp1; int fp2;
    int e_p1; int e_p2; int e_cnt; int e_st;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  preg_freelist_if ifc ();
  preg_freelist dut (.clk(clk), .reset(reset), .fl(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: available pregs in allocation order, plus allocation history for rollback.
  int fl_q[$];
  int hist[$];
  bit inuse[NUM_PREGS];
  bit tvalid[MAX_PREDICT_DEPTH];
  int tlen[MAX_PREDICT_DEPTH];
  vec_t tbl[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_in(input int an, input int ae, input int fn, input int fp1, input int fp2,
                        input int ck, input int ckt, input int sd, input int sdt);
    ifc.alloc_num                     = 2'(an);
    ifc.alloc_en                      = (ae != 0);
    ifc.free_num                      = 2'(fn);
    ifc.free_preg1                    = preg_t'(fp1);
    ifc.free_preg2                    = preg_t'(fp2);
    ifc.ckpt_en                       = (ck != 0);
    ifc.ckpt_tag                      = br_tag_t'(ckt);
    ifc.freelist_branch_shootdown     = (sd != 0);
    ifc.freelist_shootdown_branch_tag = br_tag_t'(sdt);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #7;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
  endtask

  task automatic model_init();
    fl_q.delete();
    hist.delete();
    for (int p = 1; p < NUM_PREGS; p++) fl_q.push_back(p);
    for (int p = 0; p < NUM_PREGS; p++) inuse[p] = 1'b0;
    for (int t = 0; t < MAX_PREDICT_DEPTH; t++) begin
      tvalid[t] = 1'b0;
      tlen[t]   = 0;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    tbl[0] = '{2, 1, 0, 0, 0, 1, 2, 63, 0};
    tbl[1] = '{0, 0, 0, 0, 0, 3, 4, 61, 0};
    tbl[2] = '{2, 1, 2, 7, 9, 3, 4, 61, 0};
    tbl[3] = '{1, 1, 0, 0, 0, 5, 6, 61, 0};
    tbl[4] = '{0, 0, 0, 0, 0, 6, 7, 60, 0};
    tbl[5] = '{2, 0, 0, 0, 0, 6, 7, 60, 0};

    do_reset();
    chk("reset_preg1", int'(ifc.preg1), 1);
    chk("reset_preg2", int'(ifc.preg2), 2);
    chk("reset_count", int'(ifc.free_count), 63);
    chk("reset_stalled", int'(ifc.stalled), 0);
`ifdef FREELIST_DOUBLE_FREE_CHECK_EN
    chk("reset_dferr", int'(ifc.double_free_err), 0);
`endif

    for (int v = 0; v < 6; v++) begin
      set_in(tbl[v].an, tbl[v].ae, tbl[v].fn, tbl[v].fp1, tbl[v].fp2, 0, 0, 0, 0);
      #1;
      chk($sformatf("vec%0d_preg1", v), int'(ifc.preg1), tbl[v].e_p1);
      chk($sformatf("vec%0d_preg2", v), int'(ifc.preg2), tbl[v].e_p2);
      chk($sformatf("vec%0d_count", v), int'(ifc.free_count), tbl[v].e_cnt);
      chk($sformatf("vec%0d_stalled", v), int'(ifc.stalled), tbl[v].e_st);
      step();
    end

    // Checkpoint at head 4, tag-0 shootdown is a no-op, tag-1 restore, discarded same-cycle ckpt.
    do_reset();
    set_in(2, 1, 0, 0, 0, 0, 0, 0, 0); step();
    set_in(2, 1, 0, 0, 0, 1, 1, 0, 0); step();
    repeat (3) begin
      set_in(2, 1, 0, 0, 0, 0, 0, 0, 0); step();
    end
    set_in(1, 1, 0, 0, 0, 0, 0, 1, 0); #1;
    chk("ckpt_head10_preg1", int'(ifc.preg1), 11);
    chk("ckpt_head10_count", int'(ifc.free_count), 53);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("sd_tag0_preg1", int'(ifc.preg1), 12);
    chk("sd_tag0_count", int'(ifc.free_count), 52);
    set_in(2, 1, 0, 0, 0, 1, 2, 1, 1); step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("sd_tag1_preg1", int'(ifc.preg1), 5);
    chk("sd_tag1_preg2", int'(ifc.preg2), 6);
    chk("sd_tag1_count", int'(ifc.free_count), 59);
    chk("sd_tag1_stalled", int'(ifc.stalled), 0);
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 2); step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("sd_tag2_preg1", int'(ifc.preg1), 1);
    chk("sd_tag2_count", int'(ifc.free_count), 63);

    // Drain to one entry, stall, then a release re-enables allocation a cycle later.
    do_reset();
    repeat (31) begin
      set_in(2, 1, 0, 0, 0, 0, 0, 0, 0); step();
    end
    set_in(2, 1, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("stall_count1", int'(ifc.free_count), 1);
    chk("stall_preg1", int'(ifc.preg1), 63);
    chk("stall_asserted", int'(ifc.stalled), 1);
    step();
    set_in(2, 1, 1, 5, 0, 0, 0, 0, 0); #1;
    chk("stall_head_held", int'(ifc.free_count), 1);
    chk("stall_free_same_cycle", int'(ifc.stalled), 1);
    step();
    set_in(2, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("stall_released", int'(ifc.stalled), 0);
    chk("stall_count2", int'(ifc.free_count), 2);
    chk("stall_wrap_preg1", int'(ifc.preg1), 63);
    chk("stall_wrap_preg2", int'(ifc.preg2), 5);
    set_in(2, 1, 0, 0, 0, 0, 0, 0, 0); step();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("empty_count", int'(ifc.free_count), 0);
    chk("empty_stalled", int'(ifc.stalled), 1);

`ifdef FREELIST_DOUBLE_FREE_CHECK_EN
    do_reset();
    repeat (5) begin
      set_in(2, 1, 0, 0, 0, 0, 0, 0, 0); step();
    end
    set_in(0, 0, 1, 10, 0, 0, 0, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("df_first_count", int'(ifc.free_count), 54);
    chk("df_first_err", int'(ifc.double_free_err), 0);
    set_in(0, 0, 1, 10, 0, 0, 0, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("df_second_count", int'(ifc.free_count), 54);
    chk("df_second_err", int'(ifc.double_free_err), 1);
    step();
    chk("df_err_pulse", int'(ifc.double_free_err), 0);
`endif

    // Randomized traffic against the queue model.
    do_reset();
    model_init();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int an, ae, fn, p1, p2, ck, ckt, sd, sdt, cnt, maxlen, n, i1;
      int cand[$];
      int vt[$];
      bit spec[NUM_PREGS];
      bit stall;
      cand.delete();
      vt.delete();
      an  = int'($urandom_range(0, 2));
      ae  = ($urandom_range(0, 3) != 0) ? 1 : 0;
      sd  = 0; sdt = 0; ck = 0; ckt = 0; p1 = 0; p2 = 0;
      for (int t = 0; t < MAX_PREDICT_DEPTH; t++) if (tvalid[t]) vt.push_back(t);
      if (vt.size() > 0 && $urandom_range(0, 11) == 0) begin
        sd  = 1;
        sdt = vt[$urandom_range(0, vt.size() - 1)] + 1;
      end else if ($urandom_range(0, 29) == 0) begin
        sd  = 1;
        sdt = 0;
      end
      if (!(sd != 0 && sdt != 0) && $urandom_range(0, 5) == 0) begin
        ck  = 1;
        ckt = int'($urandom_range(0, MAX_PREDICT_DEPTH));
      end
      maxlen = 0;
      for (int t = 0; t < MAX_PREDICT_DEPTH; t++) if (tvalid[t] && tlen[t] > maxlen) maxlen = tlen[t];
      for (int p = 0; p < NUM_PREGS; p++) spec[p] = 1'b0;
      for (int k = hist.size() - maxlen; k < hist.size(); k++) spec[hist[k]] = 1'b1;
      for (int p = 0; p < NUM_PREGS; p++) if (inuse[p] && !spec[p]) cand.push_back(p);
      fn = int'($urandom_range(0, (cand.size() < 2) ? cand.size() : 2));
      if (fn >= 1) begin
        i1 = int'($urandom_range(0, cand.size() - 1));
        p1 = cand[i1];
        cand.delete(i1);
      end
      if (fn == 2) p2 = cand[$urandom_range(0, cand.size() - 1)];

      set_in(an, ae, fn, p1, p2, ck, ckt, sd, sdt);
      #1;
      cnt   = fl_q.size();
      stall = (cnt < an);
      chk("rnd_count", int'(ifc.free_count), cnt);
      chk("rnd_stalled", int'(ifc.stalled), stall ? 1 : 0);
      if (cnt >= 1) chk("rnd_preg1", int'(ifc.preg1), fl_q[0]);
      if (cnt >= 2) chk("rnd_preg2", int'(ifc.preg2), fl_q[1]);
      step();

      if (sd != 0 && sdt != 0) begin
        n = tlen[sdt - 1];
        repeat (n) begin
          int p;
          p = hist.pop_back();
          fl_q.push_front(p);
          inuse[p] = 1'b0;
        end
        for (int u = 0; u < MAX_PREDICT_DEPTH; u++) begin
          if (tvalid[u]) begin
            if (tlen[u] >= n) tlen[u] -= n;
            else tvalid[u] = 1'b0;
          end
        end
      end else if (ae != 0 && !stall) begin
        for (int k = 0; k < an; k++) begin
          int p;
          p = fl_q.pop_front();
          inuse[p] = 1'b1;
          hist.push_back(p);
          for (int u = 0; u < MAX_PREDICT_DEPTH; u++) if (tvalid[u]) tlen[u]++;
        end
      end
      if (ck != 0 && ckt != 0) begin
        tvalid[ckt - 1] = 1'b1;
        tlen[ckt - 1]   = 0;
      end
      if (fn >= 1) begin
        fl_q.push_back(p1);
        inuse[p1] = 1'b0;
      end
      if (fn == 2) begin
        fl_q.push_back(p2);
        inuse[p2] = 1'b0;
      end
      if ($urandom_range(0, 9) == 0) tvalid[$urandom_range(0, MAX_PREDICT_DEPTH - 1)] = 1'b0;
    end

    // Asynchronous reset in the middle of a cycle takes effect immediately.
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_count", int'(ifc.free_count), 63);
    chk("async_reset_preg1", int'(ifc.preg1), 1);
    chk("async_reset_preg2", int'(ifc.preg2), 2);
    chk("async_reset_stalled", int'(ifc.stalled), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
